// File: rtl/sched_pkg.sv
// sched_pkg: shared widths, task_in field layout and err bit indices for the
// scheduler monitor (sched_monitor, sched_mon_table).
// Optional feature macro used by the monitor: SCHED_MON_CTXSW_EN.
package sched_pkg;
  localparam int TASK_ID_W    = 16;
  localparam int LEN_W        = 4;
  localparam int TASK_IN_W    = 20;

  // task_in = {length, id}
  localparam int TASK_ID_LSB  = 0;
  localparam int TASK_ID_MSB  = 15;
  localparam int TASK_LEN_LSB = 16;
  localparam int TASK_LEN_MSB = 19;

  // Sticky error flag positions
  localparam int ERR_W          = 3;
  localparam int ERR_OVERFLOW   = 0;
  localparam int ERR_UNKNOWN_ID = 1;
  localparam int ERR_ZERO_LEN   = 2;

  typedef struct packed {
    logic [LEN_W-1:0]     len;
    logic [TASK_ID_W-1:0] id;
  } task_word_t;

  function automatic task_word_t unpack_task(input logic [TASK_IN_W-1:0] word);
    task_word_t t;
    t.id  = word[TASK_ID_MSB:TASK_ID_LSB];
    t.len = word[TASK_LEN_MSB:TASK_LEN_LSB];
    return t;
  endfunction
endpackage

// File: rtl/sched_mon_table.sv
// sched_mon_table: tracked-task table. Holds {id, length, arrival time,
// executions so far, valid} per entry, with a lowest-index match encoder for
// the executing id and a lowest-index free-slot encoder for new arrivals.
// Both encoders see only pre-edge contents, so a slot freed by a completion
// becomes writable on the following cycle.
module sched_mon_table
  import sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [TASK_ID_W-1:0] wr_id,
  input  logic [LEN_W-1:0]     wr_len,
  input  logic [TS_W-1:0]      wr_arr,
  input  logic                 lk_en,
  input  logic [TASK_ID_W-1:0] lk_id,
  output logic                 full,
  output logic                 lk_hit,
  output logic                 lk_last,
  output logic [LEN_W-1:0]     lk_len,
  output logic [TS_W-1:0]      lk_arr
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 valid_reg [DEPTH];
  logic [TASK_ID_W-1:0] id_reg    [DEPTH];
  logic [LEN_W-1:0]     len_reg   [DEPTH];
  logic [TS_W-1:0]      arr_reg   [DEPTH];
  logic [LEN_W-1:0]     exec_reg  [DEPTH];

  logic [DEPTH-1:0] match_vec;
  logic [DEPTH-1:0] free_vec;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] free_idx;
  logic             free_any;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match_vec[gi] = valid_reg[gi] && (id_reg[gi] == lk_id);
      assign free_vec[gi]  = !valid_reg[gi];
    end
  endgenerate

  // Priority encoders: lowest matching entry and lowest free entry.
  always_comb begin
    lk_hit   = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        lk_hit  = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (free_vec[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign full    = !free_any;
  assign lk_len  = len_reg[hit_idx];
  assign lk_arr  = arr_reg[hit_idx];
  assign lk_last = lk_hit && ((exec_reg[hit_idx] + LEN_W'(1)) == len_reg[hit_idx]);

  // Entry update: store an arrival in the free slot, or advance/free the executing entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst || clr) begin
        valid_reg[i] <= 1'b0;
        id_reg[i]    <= '0;
        len_reg[i]   <= '0;
        arr_reg[i]   <= '0;
        exec_reg[i]  <= '0;
      end else if (wr_en && free_any && (free_idx == IDX_W'(i))) begin
        valid_reg[i] <= 1'b1;
        id_reg[i]    <= wr_id;
        len_reg[i]   <= wr_len;
        arr_reg[i]   <= wr_arr;
        exec_reg[i]  <= '0;
      end else if (lk_en && lk_hit && (hit_idx == IDX_W'(i))) begin
        if (lk_last) begin
          valid_reg[i] <= 1'b0;
        end else begin
          exec_reg[i] <= exec_reg[i] + LEN_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/sched_monitor.sv
// sched_monitor: snoops a scheduler's input and execution streams, timestamps
// each task, and reports per-task turnaround/wait plus running statistics.
// Optional context-switch counter enabled by defining SCHED_MON_CTXSW_EN.
module sched_monitor
  import sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic                 inputtask,
  input  logic [TASK_IN_W-1:0] task_in,
  input  logic                 empty,
  input  logic [TASK_ID_W-1:0] task_out,
  output logic                 done_valid,
  output logic [TASK_ID_W-1:0] done_id,
  output logic [TS_W-1:0]      done_turnaround,
  output logic [TS_W-1:0]      done_wait,
  output logic [7:0]           total_done,
  output logic [15:0]          sum_wait,
  output logic [ERR_W-1:0]     err
`ifdef SCHED_MON_CTXSW_EN
  ,
  output logic [15:0]          ctxsw_cnt
`endif
);
  task_word_t in_task;
  logic arrive, store, exec_en, complete, full, lk_hit, lk_last;
  logic [LEN_W-1:0] lk_len;
  logic [TS_W-1:0]  lk_arr, turnaround_next, wait_next;
  logic [16:0]      sum_ext;

  logic                 t_phase_reg;
  logic [TS_W-1:0]      t_reg;
  logic                 done_valid_reg;
  logic [TASK_ID_W-1:0] done_id_reg;
  logic [TS_W-1:0]      done_ta_reg, done_wait_reg;
  logic [7:0]           total_done_reg;
  logic [15:0]          sum_wait_reg;
  logic [ERR_W-1:0]     err_reg;

  // A start cycle masks both snooped streams.
  assign in_task  = unpack_task(task_in);
  assign arrive   = inputtask && !st;
  assign store    = arrive && (in_task.len != '0);
  assign exec_en  = !empty && !st;
  assign complete = exec_en && lk_last;

  assign turnaround_next = t_reg - lk_arr + TS_W'(1);
  assign wait_next       = turnaround_next - TS_W'(lk_len);
  assign sum_ext         = {1'b0, sum_wait_reg} + 17'(wait_next);

  sched_mon_table #(.DEPTH(DEPTH), .TS_W(TS_W)) u_table (
    .clk    (clk),
    .rst    (rst),
    .clr    (st),
    .wr_en  (store),
    .wr_id  (in_task.id),
    .wr_len (in_task.len),
    .wr_arr (t_reg),
    .lk_en  (exec_en),
    .lk_id  (task_out),
    .full   (full),
    .lk_hit (lk_hit),
    .lk_last(lk_last),
    .lk_len (lk_len),
    .lk_arr (lk_arr)
  );

  // Timestamp: advances once every two cycles, restarted by st.
  always_ff @(posedge clk) begin
    if (!rst || st) begin
      t_phase_reg <= 1'b0;
      t_reg       <= '0;
    end else begin
      t_phase_reg <= !t_phase_reg;
      if (t_phase_reg) t_reg <= t_reg + TS_W'(1);
    end
  end

  // Completion report and saturating statistics, visible the cycle after completion.
  always_ff @(posedge clk) begin
    if (!rst || st) begin
      done_valid_reg <= 1'b0;
      done_id_reg    <= '0;
      done_ta_reg    <= '0;
      done_wait_reg  <= '0;
      total_done_reg <= '0;
      sum_wait_reg   <= '0;
    end else begin
      done_valid_reg <= complete;
      if (complete) begin
        done_id_reg   <= task_out;
        done_ta_reg   <= turnaround_next;
        done_wait_reg <= wait_next;
        if (total_done_reg != 8'hFF) total_done_reg <= total_done_reg + 8'd1;
        sum_wait_reg  <= sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
      end
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst || st) begin
      err_reg <= '0;
    end else begin
      if (arrive && (in_task.len == '0)) err_reg[ERR_ZERO_LEN]   <= 1'b1;
      if (store && full)                 err_reg[ERR_OVERFLOW]   <= 1'b1;
      if (exec_en && !lk_hit)            err_reg[ERR_UNKNOWN_ID] <= 1'b1;
    end
  end

  assign done_valid      = done_valid_reg;
  assign done_id         = done_id_reg;
  assign done_turnaround = done_ta_reg;
  assign done_wait       = done_wait_reg;
  assign total_done      = total_done_reg;
  assign sum_wait        = sum_wait_reg;
  assign err             = err_reg;

`ifdef SCHED_MON_CTXSW_EN
  logic                 prev_idle_reg;
  logic [TASK_ID_W-1:0] prev_id_reg;
  logic [15:0]          ctxsw_reg;

  // Context switch: a new id runs, or anything runs after an idle or completing cycle.
  always_ff @(posedge clk) begin
    if (!rst || st) begin
      prev_idle_reg <= 1'b1;
      prev_id_reg   <= '0;
      ctxsw_reg     <= '0;
    end else begin
      if (!empty && (prev_idle_reg || (task_out != prev_id_reg)) && (ctxsw_reg != 16'hFFFF))
        ctxsw_reg <= ctxsw_reg + 16'd1;
      prev_idle_reg <= empty || complete;
      if (!empty) prev_id_reg <= task_out;
    end
  end

  assign ctxsw_cnt = ctxsw_reg;
`endif
endmodule

// File: tb/tb_sched_monitor.sv
// tb_sched_monitor: directed scenarios plus randomized traffic, every cycle
// compared against a task-level reference model (timestamps derived from the
// cycle count since the last start/reset, table kept as an array of records).
module tb_sched_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st = 1'b0;
  logic        inputtask = 1'b0;
  logic [19:0] task_in = '0;
  logic        empty = 1'b1;
  logic [15:0] task_out = '0;
  logic        done_valid;
  logic [15:0] done_id;
  logic [7:0]  done_turnaround, done_wait, total_done;
  logic [15:0] sum_wait;
  logic [2:0]  err;
`ifdef SCHED_MON_CTXSW_EN
  logic [15:0] ctxsw_cnt;
`endif

  sched_monitor #(.DEPTH(8), .TS_W(8)) dut (
    .clk(clk), .rst(rst), .st(st), .inputtask(inputtask), .task_in(task_in),
    .empty(empty), .task_out(task_out), .done_valid(done_valid), .done_id(done_id),
    .done_turnaround(done_turnaround), .done_wait(done_wait),
    .total_done(total_done), .sum_wait(sum_wait), .err(err)
`ifdef SCHED_MON_CTXSW_EN
    , .ctxsw_cnt(ctxsw_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  typedef struct {
    bit          v;
    logic [15:0] id;
    int          len;
    int          arr;
    int          ex;
  } slot_t;
  slot_t       slots [8];
  int          m_cycle;
  bit          m_dv, m_clr, m_prev_idle;
  int          m_id, m_ta, m_wt, m_total, m_sum, m_err, m_ctx;
  logic [15:0] m_prev_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the task-level rules to the model.
  task automatic model_edge();
    int t, hit, fr, len;
    bit comp;
    m_clr = 1'b0;
    if (!rst || st) begin
      for (int i = 0; i < 8; i++) slots[i].v = 1'b0;
      m_cycle = 0; m_dv = 0; m_id = 0; m_ta = 0; m_wt = 0;
      m_total = 0; m_sum = 0; m_err = 0; m_ctx = 0;
      m_prev_idle = 1'b1; m_prev_id = '0; m_clr = 1'b1;
    end else begin
      t = (m_cycle / 2) % 256;
      m_cycle++;
      hit = -1; fr = -1; comp = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (slots[i].v && slots[i].id == task_out) hit = i;
        if (!slots[i].v) fr = i;
      end
      m_dv = 1'b0;
      if (!empty) begin
        if (hit < 0) m_err |= 2;
        else if (slots[hit].ex + 1 == slots[hit].len) begin
          comp = 1'b1;
          m_dv = 1'b1;
          m_id = slots[hit].id;
          m_ta = (t - slots[hit].arr + 1) & 255;
          m_wt = (m_ta - slots[hit].len) & 255;
          if (m_total < 255) m_total++;
          m_sum = (m_sum + m_wt > 65535) ? 65535 : m_sum + m_wt;
          slots[hit].v = 1'b0;
        end else slots[hit].ex++;
      end
      if (inputtask) begin
        len = int'(task_in[19:16]);
        if (len == 0) m_err |= 4;
        else if (fr < 0) m_err |= 1;
        else begin
          slots[fr].v = 1'b1; slots[fr].id = task_in[15:0];
          slots[fr].len = len; slots[fr].arr = t; slots[fr].ex = 0;
        end
      end
      if (!empty && (m_prev_idle || task_out != m_prev_id) && m_ctx < 65535) m_ctx++;
      m_prev_idle = empty || comp;
      if (!empty) m_prev_id = task_out;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("done_valid", done_valid, m_dv);
    if (m_dv || m_clr) begin
      check("done_id", done_id, m_id);
      check("done_turnaround", done_turnaround, m_ta);
      check("done_wait", done_wait, m_wt);
    end
    check("total_done", total_done, m_total);
    check("sum_wait", sum_wait, m_sum);
    check("err", err, m_err);
`ifdef SCHED_MON_CTXSW_EN
    check("ctxsw_cnt", ctxsw_cnt, m_ctx);
`endif
    if (done_valid)
      $display("done id=%0h turnaround=%0d wait=%0d total=%0d sum=%0d",
               done_id, done_turnaround, done_wait, total_done, sum_wait);
  endtask

  task automatic cyc(input logic it, input logic [3:0] len, input logic [15:0] id,
                     input logic emp, input logic [15:0] to);
    inputtask = it; task_in = {len, id}; empty = emp; task_out = to;
    step();
  endtask

  // Start pulse with live-looking inputs that must be ignored.
  task automatic do_start();
    st = 1'b1;
    cyc(1'b1, 4'd3, 16'h0001, 1'b0, 16'h0001);
    st = 1'b0;
    check("start_total", total_done, 0);
    check("start_err", err, 0);
  endtask

  logic        s_it, s_emp;
  logic [3:0]  s_len;
  logic [15:0] s_id, s_to;
  int          s_t;

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 16'h0, 1'b1, 16'h0);
    check("rst_done_valid", done_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b1;

    // FCFS run: {7,1}@T0, {4,2}@T2, {1,3}@T4; one execution per timestamp
    do_start();
    for (int c = 0; c < 26; c++) begin
      s_t = c / 2;
      s_it = 1'b0; s_len = 4'd0; s_id = 16'h0; s_emp = 1'b1; s_to = 16'h0;
      if (c == 0) begin s_it = 1'b1; s_len = 4'd7; s_id = 16'd1; end
      if (c == 4) begin s_it = 1'b1; s_len = 4'd4; s_id = 16'd2; end
      if (c == 8) begin s_it = 1'b1; s_len = 4'd1; s_id = 16'd3; end
      if (c % 2 == 0 && s_t >= 1 && s_t <= 12) begin
        s_emp = 1'b0;
        s_to = (s_t <= 7) ? 16'd1 : (s_t <= 11) ? 16'd2 : 16'd3;
      end
      cyc(s_it, s_len, s_id, s_emp, s_to);
      if (c == 14) begin
        check("id1_valid", done_valid, 1); check("id1_id", done_id, 1);
        check("id1_ta", done_turnaround, 8); check("id1_wait", done_wait, 1);
      end
      if (c == 22) begin
        check("id2_id", done_id, 2); check("id2_ta", done_turnaround, 10);
        check("id2_wait", done_wait, 6);
      end
      if (c == 24) begin
        check("id3_id", done_id, 3); check("id3_ta", done_turnaround, 9);
        check("id3_wait", done_wait, 8);
      end
    end
    check("fcfs_total", total_done, 3);
    check("fcfs_sum", sum_wait, 15);

    // Overflow: nine arrivals, no execution
    do_start();
    for (int i = 0; i < 9; i++) cyc(1'b1, 4'd1, 16'h0010 + 16'(i), 1'b1, 16'h0);
    check("ovf_err", err, 3'b001);
    cyc(1'b1, 4'd1, 16'h0021, 1'b0, 16'h0013);   // freed slot not yet usable
    check("ovf_free_id", done_id, 16'h0013);
    cyc(1'b1, 4'd2, 16'h0020, 1'b1, 16'h0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h0021);
    check("ovf_drop_same_cycle", err, 3'b011);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h0020);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h0020);
    check("ovf_stored_valid", done_valid, 1);
    check("ovf_stored_id", done_id, 16'h0020);

    // Unknown id and zero-length arrival
    do_start();
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h00FF);
    check("unknown_err", err, 3'b010);
    cyc(1'b1, 4'd0, 16'h0005, 1'b1, 16'h0);
    check("zero_len_err", err, 3'b110);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h0005);
    check("zero_len_not_stored", done_valid, 0);

    // Reset mid-run with two tasks in flight
    do_start();
    cyc(1'b1, 4'd3, 16'h000A, 1'b1, 16'h0);
    cyc(1'b1, 4'd3, 16'h000B, 1'b1, 16'h0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h000A);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h000B);
    rst = 1'b0;
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'h000A);
    rst = 1'b1;
    check("midrst_valid", done_valid, 0); check("midrst_id", done_id, 0);
    check("midrst_ta", done_turnaround, 0); check("midrst_wait", done_wait, 0);
    check("midrst_total", total_done, 0); check("midrst_sum", sum_wait, 0);
    check("midrst_err", err, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'd0, 16'h0, 1'b1, 16'h0);
      check("midrst_no_pulse", done_valid, 0);
    end
    check("midrst_err_after", err, 0);

`ifdef SCHED_MON_CTXSW_EN
    // Round-robin 1,2,1,2
    do_start();
    cyc(1'b1, 4'd4, 16'd1, 1'b1, 16'h0);
    cyc(1'b1, 4'd4, 16'd2, 1'b1, 16'h0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'd1);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'd2);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'd1);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 16'd2);
    check("rr_ctxsw", ctxsw_cnt, 4);
`endif

    // Randomized traffic against the model, including rare start/reset
    do_start();
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 299) != 0);
      st        = ($urandom_range(0, 299) == 0);
      inputtask = ($urandom_range(0, 9) < 3);
      task_in   = {4'($urandom_range(0, 15)), 16'($urandom_range(1, 6))};
      empty     = ($urandom_range(0, 9) < 4);
      task_out  = 16'($urandom_range(1, 7));
      step();
      rst = 1'b1;
      st  = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
